// File: rtl/wb_regfile_pkg.sv
// Shared writeback/load select codes for the core's writeback stage.
package wb_regfile_pkg;

  localparam logic [1:0] REG_RES       = 2'd0;
  localparam logic [1:0] REG_MEM       = 2'd1;
  localparam logic [1:0] REG_PC_PLUS_4 = 2'd2;

  localparam logic [2:0] LOAD_W  = 3'd0;
  localparam logic [2:0] LOAD_H  = 3'd1;
  localparam logic [2:0] LOAD_HU = 3'd2;
  localparam logic [2:0] LOAD_B  = 3'd3;
  localparam logic [2:0] LOAD_BU = 3'd4;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_regfile_load_ext.sv
// Load data formatting: selects the byte/halfword lane and sign- or zero-extends it.
module wb_regfile_load_ext
  import wb_regfile_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_off,
  input  logic [2:0]  load_sel,
  output logic [31:0] load_data
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  always_comb begin
    half_lane = mem_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (mem_off)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
  end

  // NOTE: the default arm covers every unlisted code, so no latch is inferred
  // and undefined load_sel values behave as a full-word load.
  always_comb begin
    case (load_sel)
      LOAD_H:  load_data = {{16{half_lane[15]}}, half_lane};
      LOAD_HU: load_data = {16'h0, half_lane};
      LOAD_B:  load_data = {{24{byte_lane[7]}}, byte_lane};
      LOAD_BU: load_data = {24'h0, byte_lane};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file (x0 hardwired to zero).
// Optional write-through read bypass: define WB_BYPASS_EN.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      rd,
  input  logic            reg_we,
  input  logic [1:0]      reg_sel,
  input  logic [2:0]      load_sel,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] pc_plus_4,
  input  logic [31:0]     mem_rdata,
  input  logic [1:0]      mem_off,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_we_q,
  output logic [4:0]      wb_rd_q,
  output logic [XLEN-1:0] wb_data_q,
  output logic [63:0]     instret
);

  logic [XLEN-1:0] regs [NREGS];
  logic [31:0]     load_data;
  logic [XLEN-1:0] wb_data;
  logic            do_write;

  wb_regfile_load_ext u_load_ext (
    .mem_rdata (mem_rdata),
    .mem_off   (mem_off),
    .load_sel  (load_sel),
    .load_data (load_data)
  );

  always_comb begin
    case (reg_sel)
      REG_MEM:       wb_data = load_data;
      REG_PC_PLUS_4: wb_data = pc_plus_4;
      default:       wb_data = alu_res;
    endcase
  end

  assign do_write = reg_we && (rd != ZERO_REG);

  // NOTE: the array is cleared on reset because architectural state must read
  // zero after reset; this costs a reset net on every bit of the file.
  // NOTE: all state here uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= ZERO_REG;
      wb_data_q <= '0;
      instret   <= '0;
    end else begin
      if (do_write) regs[rd] <= wb_data;
      wb_we_q   <= do_write;
      wb_rd_q   <= rd;
      wb_data_q <= wb_data;
      if (reg_we) instret <= instret + 64'd1;
    end
  end

  always_comb begin
    rs1_data = (rs1 == ZERO_REG) ? '0 : regs[rs1];
    rs2_data = (rs2 == ZERO_REG) ? '0 : regs[rs2];
`ifdef WB_BYPASS_EN
    // Write-through removes the decode/writeback read-after-write hazard.
    if (do_write && rs1 == rd) rs1_data = wb_data;
    if (do_write && rs2 == rd) rs2_data = wb_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table, corner sequences, random vs. model.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rd, rs1, rs2;
  logic        reg_we;
  logic [1:0]  reg_sel, mem_off;
  logic [2:0]  load_sel;
  logic [31:0] alu_res, pc_plus_4, mem_rdata;
  logic [31:0] rs1_data, rs2_data, wb_data_q;
  logic        wb_we_q;
  logic [4:0]  wb_rd_q;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [31:0] m_regs [32];
  logic        m_we_q;
  logic [4:0]  m_rd_q;
  logic [31:0] m_data_q;
  logic [63:0] m_instret;

  wb_regfile dut (
    .clock(clock), .reset(reset), .rd(rd), .reg_we(reg_we), .reg_sel(reg_sel),
    .load_sel(load_sel), .alu_res(alu_res), .pc_plus_4(pc_plus_4),
    .mem_rdata(mem_rdata), .mem_off(mem_off), .rs1(rs1), .rs2(rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_we_q(wb_we_q),
    .wb_rd_q(wb_rd_q), .wb_data_q(wb_data_q), .instret(instret)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Load formatting from the lane/extension rules using shifts and masks.
  function automatic logic [31:0] ref_load(input logic [2:0] sel, input logic [1:0] off,
                                           input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (8 * off)) & 32'hFF;
    h = (data >> (16 * (off / 2))) & 32'hFFFF;
    case (sel)
      LOAD_B:  return (b >= 32'h80)   ? b - 32'h100   : b;
      LOAD_BU: return b;
      LOAD_H:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      LOAD_HU: return h;
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] ref_wb();
    if (reg_sel == REG_MEM)       return ref_load(load_sel, mem_off, mem_rdata);
    if (reg_sel == REG_PC_PLUS_4) return pc_plus_4;
    return alu_res;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (reset && reg_we && rd != 0 && a == rd) return ref_wb();
`endif
    return m_regs[a];
  endfunction

  // One clock edge; the model consumes the inputs that were stable before it.
  task automatic step();
    logic        r, we;
    logic [4:0]  d;
    logic [31:0] wd;
    r = reset; we = reg_we; d = rd; wd = ref_wb();
    @(posedge clock);
    #1;
    if (!r) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_we_q = 1'b0; m_rd_q = 5'd0; m_data_q = 32'h0; m_instret = 64'd0;
    end else begin
      if (we && d != 0) m_regs[d] = wd;
      m_we_q = we && d != 0;
      m_rd_q = d;
      m_data_q = wd;
      if (we) m_instret = m_instret + 64'd1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " rs1_data"}, rs1_data, ref_read(rs1));
    check({tag, " rs2_data"}, rs2_data, ref_read(rs2));
    check({tag, " wb_we_q"}, wb_we_q, m_we_q);
    check({tag, " wb_rd_q"}, wb_rd_q, m_rd_q);
    check({tag, " wb_data_q"}, wb_data_q, m_data_q);
    check({tag, " instret"}, instret, m_instret);
  endtask

  task automatic idle();
    reg_we = 0; rd = 0; reg_sel = REG_RES; load_sel = LOAD_W;
    alu_res = 0; pc_plus_4 = 0; mem_rdata = 0; mem_off = 0; rs1 = 0; rs2 = 0;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic [1:0]  rsel;
    logic [2:0]  lsel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] mem;
    logic [1:0]  off;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"lb off3",   5'd2,  REG_MEM, LOAD_B,  32'h0, 32'h0, 32'h80F17F01, 2'd3, 32'hFFFFFF80};
    vecs[1]  = '{"lbu off3",  5'd3,  REG_MEM, LOAD_BU, 32'h0, 32'h0, 32'h80F17F01, 2'd3, 32'h00000080};
    vecs[2]  = '{"lh off2",   5'd4,  REG_MEM, LOAD_H,  32'h0, 32'h0, 32'h80F17F01, 2'd2, 32'hFFFF80F1};
    vecs[3]  = '{"lhu off0",  5'd6,  REG_MEM, LOAD_HU, 32'h0, 32'h0, 32'h80F17F01, 2'd0, 32'h00007F01};
    vecs[4]  = '{"lw off1",   5'd8,  REG_MEM, LOAD_W,  32'h0, 32'h0, 32'h80F17F01, 2'd1, 32'h80F17F01};
    vecs[5]  = '{"lb off2",   5'd9,  REG_MEM, LOAD_B,  32'h0, 32'h0, 32'h80F17F01, 2'd2, 32'hFFFFFFF1};
    vecs[6]  = '{"lbu off1",  5'd10, REG_MEM, LOAD_BU, 32'h0, 32'h0, 32'h80F17F01, 2'd1, 32'h0000007F};
    vecs[7]  = '{"lh off1",   5'd11, REG_MEM, LOAD_H,  32'h0, 32'h0, 32'h80F17F01, 2'd1, 32'h00007F01};
    vecs[8]  = '{"lh off3",   5'd12, REG_MEM, LOAD_H,  32'h0, 32'h0, 32'h80F17F01, 2'd3, 32'hFFFF80F1};
    vecs[9]  = '{"load undef",5'd13, REG_MEM, 3'd7,    32'h0, 32'h0, 32'h80F17F01, 2'd2, 32'h80F17F01};
    vecs[10] = '{"sel undef", 5'd14, 2'd3,    LOAD_W,  32'hCAFE0001, 32'h44, 32'h1, 2'd0, 32'hCAFE0001};
    vecs[11] = '{"pc+4",      5'd31, REG_PC_PLUS_4, LOAD_B, 32'h7, 32'h00000204, 32'hFF, 2'd0, 32'h00000204};

    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_we_q = 0; m_rd_q = 0; m_data_q = 0; m_instret = 0;

    // Reset held for two edges, then every register reads zero.
    idle();
    reset = 0;
    step(); step();
    reset = 1;
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0]; rs2 = 5'(31 - i); #1;
      check("reset rs1", rs1_data, 32'h0);
      check("reset rs2", rs2_data, 32'h0);
    end
    check("reset instret", instret, 64'd0);
    check("reset wb_we_q", wb_we_q, 1'b0);
    check("reset wb_rd_q", wb_rd_q, 5'd0);
    check("reset wb_data_q", wb_data_q, 32'h0);

    // Basic write of x5, visible the following cycle.
    idle(); reg_we = 1; rd = 5; alu_res = 32'hDEADBEEF;
    step();
    idle(); rs1 = 5; #1;
    check("x5 read", rs1_data, 32'hDEADBEEF);
    check("x5 wb_rd_q", wb_rd_q, 5'd5);
    check("x5 wb_data_q", wb_data_q, 32'hDEADBEEF);
    check("x5 wb_we_q", wb_we_q, 1'b1);
    check("x5 instret", instret, 64'd1);

    // Write to x0 is discarded but still counts as retired.
    idle(); reg_we = 1; rd = 0; alu_res = 32'h1234;
    step();
    idle(); rs1 = 0; #1;
    check("x0 read", rs1_data, 32'h0);
    check("x0 wb_we_q", wb_we_q, 1'b0);
    check("x0 instret", instret, 64'd2);

    // Vector table: write, then read back and inspect the forward register.
    foreach (vecs[i]) begin
      idle(); reg_we = 1; rd = vecs[i].rd; reg_sel = vecs[i].rsel; load_sel = vecs[i].lsel;
      alu_res = vecs[i].alu; pc_plus_4 = vecs[i].pc4; mem_rdata = vecs[i].mem; mem_off = vecs[i].off;
      step();
      idle(); rs2 = vecs[i].rd; #1;
      check({vecs[i].name, " read"}, rs2_data, vecs[i].exp);
      check({vecs[i].name, " fwd"}, wb_data_q, vecs[i].exp);
    end
    check("table instret", instret, 64'd14);

    // Same-cycle read of the register being written.
    idle(); reg_we = 1; rd = 1; alu_res = 32'h55;
    step();
    idle(); reg_we = 1; rd = 1; reg_sel = REG_PC_PLUS_4; pc_plus_4 = 32'h104; rs1 = 1; rs2 = 1; #1;
`ifdef WB_BYPASS_EN
    check("same-cycle rs1", rs1_data, 32'h104);
    check("same-cycle rs2", rs2_data, 32'h104);
`else
    check("same-cycle rs1", rs1_data, 32'h55);
    check("same-cycle rs2", rs2_data, 32'h55);
`endif
    step();
    idle(); rs1 = 1; #1;
    check("x1 after pc+4", rs1_data, 32'h104);

    // Reset and write on the same edge: reset wins.
    idle(); reg_we = 1; rd = 7; alu_res = 32'hAA;
    step();
    idle(); rs1 = 7; #1;
    check("x7 pre-reset", rs1_data, 32'hAA);
    reg_we = 1; rd = 7; alu_res = 32'hBB; reset = 0;
    step();
    reset = 1; idle(); rs1 = 7; #1;
    check("x7 after reset", rs1_data, 32'h0);
    check("instret after reset", instret, 64'd0);
    check("wb_we_q after reset", wb_we_q, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reg_we    = ($urandom_range(0, 3) != 0);
      rd        = 5'($urandom_range(0, 31));
      reg_sel   = 2'($urandom_range(0, 3));
      load_sel  = 3'($urandom_range(0, 7));
      alu_res   = $urandom;
      pc_plus_4 = $urandom;
      mem_rdata = $urandom;
      mem_off   = 2'($urandom_range(0, 3));
      rs1       = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2       = 5'($urandom_range(0, 31));
      reset     = ($urandom_range(0, 99) != 0);
      #1;
      check("rand pre rs1", rs1_data, ref_read(rs1));
      check("rand pre rs2", rs2_data, ref_read(rs2));
      step();
      reset = 1; reg_we = 0; #1;
      check_model("rand post");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file for the 32-bit RISC-V core.
- Sits directly downstream of the writeback control register (rd, load_sel, reg_we, reg_sel), in the same cycle as that stage's registered outputs.
- Selects the writeback source, sign- or zero-extends load data, and writes x1..x31.
- Provides two combinational read ports to decode, plus a registered copy of the last write for EX-stage forwarding.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural register count; x0 is hardwired to zero

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- rd  in  5  destination register
- reg_we  in  1  write enable
- reg_sel  in  2  source select: REG_RES / REG_MEM / REG_PC_PLUS_4
- load_sel  in  3  LOAD_W / LOAD_H / LOAD_HU / LOAD_B / LOAD_BU
- alu_res  in  32  ALU/LUI/AUIPC result
- pc_plus_4  in  32  link value
- mem_rdata  in  32  raw aligned data-memory word
- mem_off  in  2  load address bits [1:0]
- rs1, rs2  in  5 each  read addresses
- rs1_data, rs2_data  out  32 each  read data
- wb_we_q  out  1  registered: a write occurred last cycle
- wb_rd_q  out  5  registered rd of that write
- wb_data_q  out  32  registered data of that write
- instret  out  64  retired-write counter

Behaviour:
- Reset (reset==0 at a rising edge):
  - x1..x31 <= 0.
  - wb_we_q <= 0, wb_rd_q <= ZERO_REG, wb_data_q <= 0, instret <= 0.
  - Any pending write in that cycle is dropped.
- Load formatting (combinational):
  - LOAD_W: word as-is; mem_off ignored.
  - LOAD_H / LOAD_HU: halfword mem_rdata[16*mem_off[1] +: 16], sign- or zero-extended; mem_off[0] ignored.
  - LOAD_B / LOAD_BU: byte mem_rdata[8*mem_off +: 8], sign- or zero-extended.
  - Undefined load_sel codes are treated as LOAD_W.
- Writeback data (combinational):
  - REG_RES -> alu_res; REG_MEM -> formatted load data; REG_PC_PLUS_4 -> pc_plus_4.
  - Undefined reg_sel -> alu_res.
- Write:
  - At a rising edge with reset==1 and reg_we==1 and rd!=0, regs[rd] <= wb_data.
  - rd==0 writes are discarded; x0 always reads 0.
- Forward register, updated every non-reset edge:
  - wb_we_q <= reg_we && rd!=0.
  - wb_rd_q <= rd.
  - wb_data_q <= wb_data.
- instret: increments by 1 on every edge where reg_we==1, regardless of rd. Wraps from 2^64-1 to 0.
- Reads: rs1_data/rs2_data are combinational reads of the array; address 0 returns 0.
- Latency:
  - A written value is visible on the read ports from the cycle after the write edge.
  - It is visible on wb_*_q in that same following cycle.
- Simultaneous events:
  - rs1 == rs2 == rd in the same cycle: both ports return the old value unless the bypass feature is enabled.
  - A write and a reset in the same edge: reset wins.

Optional Feature:
- WB_BYPASS_EN defined:
  - When reg_we==1, rd!=0 and rsN==rd, rsN_data returns the current-cycle wb_data (write-through).
  - This removes the decode/writeback hazard.
- WB_BYPASS_EN undefined: reads return array contents only. The hazard controller must stall one cycle on an rd/rs match.

Decomposition:
- Shared constants stay in the common codes include: REG_RES, REG_MEM, REG_PC_PLUS_4, LOAD_W/H/HU/B/BU, ZERO_REG.
- One natural sub-module: load_ext, purely combinational.
  - Inputs: mem_rdata, mem_off, load_sel.
  - Output: the 32-bit extended value.
  - Reused by any future store/load alignment checker.

Test Plan:
- Reset low for 2 cycles, then read all rs -> all 0, instret=0, wb_we_q=0.
- reg_we=1, rd=5, REG_RES, alu_res=0xDEADBEEF; next cycle rs1=5 -> 0xDEADBEEF; wb_rd_q=5, wb_data_q=0xDEADBEEF, wb_we_q=1, instret=1.
- rd=0, reg_we=1, alu_res=0x1234 -> rs1=0 reads 0, wb_we_q=0, instret increments.
- REG_MEM, mem_rdata=0x80F17F01:
  - LOAD_B off=3 -> 0xFFFFFF80
  - LOAD_BU off=3 -> 0x00000080
  - LOAD_H off=2 -> 0xFFFF80F1
  - LOAD_HU off=0 -> 0x00007F01
  - LOAD_W off=1 -> 0x80F17F01
- REG_PC_PLUS_4, pc_plus_4=0x104, rd=1 -> x1=0x104. Same cycle rs1=1:
  - with WB_BYPASS_EN -> 0x104
  - without -> previous x1 value
- Write x7=0xAA, then reset low for one edge together with a write to x7=0xBB -> x7=0, instret=0 afterwards.
